// File: rtl/mul_div_unit_pkg.sv
// Shared MD operation codes for the E-stage controller and the MDU.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the HI/LO result
// of an MD op; divide-by-zero leaves HI/LO at their current values.
module mdu_arith
  import mul_div_unit_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] den;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;
  logic        dz;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val})
                * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide on magnitudes keeps 0x80000000/-1 well defined.
  assign dz    = (rt_val == 32'd0);
  assign den   = dz ? 32'd1 : rt_val;
  assign neg_a = rs_val[31];
  assign neg_b = den[31];
  assign ua    = neg_a ? -rs_val : rs_val;
  assign ub    = neg_b ? -den : den;
  assign uq    = ua / ub;
  assign ur    = ua % ub;
  assign sq    = (neg_a ^ neg_b) ? -uq : uq;
  assign sr    = neg_a ? -ur : ur;

  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (md_op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        if (!dz) begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      MD_DIVU: begin
        if (!dz) begin
          res_hi = rs_val % den;
          res_lo = rs_val / den;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit: HI/LO state, pending result and
// busy countdown modelling multi-cycle MD latency.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        req,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic [31:0]   res_hi, res_lo;
  logic          is_mul, is_div, idle;

  mdu_arith u_arith (
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign idle   = !busy_q && !req;
  assign start  = idle && (is_mul || is_div);
  assign busy   = busy_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_comb begin
    rd_data = '0;
    if (md_op == MD_MFHI) rd_data = hi_q;
    if (md_op == MD_MFLO) rd_data = lo_q;
  end

  always_comb begin
    busy_d    = busy_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (start) begin
      pend_hi_d = res_hi;
      pend_lo_d = res_lo;
      busy_d    = 1'b1;
      count_d   = is_mul ? CW'(MULT_LAT) : CW'(DIV_LAT);
    end else if (busy_q) begin
      count_d = count_q - CW'(1);
      if (count_q == CW'(1)) begin
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
        busy_d = 1'b0;
      end
    end
    if (idle && md_op == MD_MTHI) hi_d = rs_val;
    if (idle && md_op == MD_MTLO) lo_d = rs_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      busy_q    <= busy_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against a plain-arithmetic
// model of HI/LO and fixed MULT/DIV latencies.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic        req;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        start;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_cmp;
  int n_err;
  logic [31:0] mhi;
  logic [31:0] mlo;

  mul_div_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op),
    .req     (req),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .start   (start),
    .busy    (busy),
    .rd_data (rd_data),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_op(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
    int          sa;
    int          sb;
    longint      p;
    longint      q;
    longint      r;
    logic [63:0] pu;
    sa = a;
    sb = b;
    case (op)
      MD_MULT: begin
        p = longint'(sa) * longint'(sb);
        mhi = p[63:32];
        mlo = p[31:0];
      end
      MD_MULTU: begin
        pu = 64'(a) * 64'(b);
        mhi = pu[63:32];
        mlo = pu[31:0];
      end
      MD_DIV: if (b != 0) begin
        q = longint'(sa) / longint'(sb);
        r = longint'(sa) % longint'(sb);
        mlo = q[31:0];
        mhi = r[31:0];
      end
      MD_DIVU: if (b != 0) begin
        mlo = a / b;
        mhi = a % b;
      end
      MD_MTHI: mhi = a;
      MD_MTLO: mlo = a;
      default: ;
    endcase
  endtask

  task automatic run_md(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output logic st,
                        output int nb);
    @(negedge clk);
    md_op = op; rs_val = a; rt_val = b;
    #1 st = start;
    @(negedge clk);
    md_op = MD_NONE;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      @(negedge clk);
    end
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    md_op = op; rs_val = v;
    @(negedge clk);
    md_op = MD_NONE;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state busy=%b hi=%h lo=%h want 0/0/0",
               busy, hi_o, lo_o);
    end
    @(negedge clk);
    reset = 1'b1;
    md_op = MD_MFHI;
    #1;
    n_cmp++;
    if (rd_data !== 32'd0 || start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mfhi rd=%h start=%b want 0/0", rd_data, start);
    end
    md_op = MD_NONE;
    mhi = 0; mlo = 0;
  endtask

  task automatic test_mult_latency;
    logic st; int nb;
    run_md(MD_MULT, 32'hFFFFFFFD, 32'd5, st, nb);
    n_cmp++;
    if (st !== 1'b1 || nb != ML) begin
      n_err++;
      $display("FAIL mult_lat start=%b busy=%0d want 1/%0d", st, nb, ML);
    end
    n_cmp++;
    if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFF1) begin
      n_err++;
      $display("FAIL mult_res hi=%h lo=%h want ffffffff/fffffff1",
               hi_o, lo_o);
    end
    mhi = 32'hFFFFFFFF; mlo = 32'hFFFFFFF1;
  endtask

  task automatic test_multu;
    logic st; int nb;
    run_md(MD_MULTU, 32'hFFFFFFFF, 32'd2, st, nb);
    n_cmp++;
    if (nb != ML || hi_o !== 32'h1 || lo_o !== 32'hFFFFFFFE) begin
      n_err++;
      $display("FAIL multu busy=%0d hi=%h lo=%h want %0d/1/fffffffe",
               nb, hi_o, lo_o, ML);
    end
    mhi = 32'h1; mlo = 32'hFFFFFFFE;
  endtask

  task automatic test_div;
    logic st; int nb;
    run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, st, nb);
    n_cmp++;
    if (nb != DL || hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFD) begin
      n_err++;
      $display("FAIL div busy=%0d hi=%h lo=%h want %0d/ffffffff/fffffffd",
               nb, hi_o, lo_o, DL);
    end
    run_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, st, nb);
    n_cmp++;
    if (hi_o !== 32'h0 || lo_o !== 32'h80000000) begin
      n_err++;
      $display("FAIL div_ovf hi=%h lo=%h want 0/80000000", hi_o, lo_o);
    end
    mhi = 32'h0; mlo = 32'h80000000;
  endtask

  task automatic test_div_zero;
    logic st; int nb;
    do_mt(MD_MTHI, 32'h1234);
    do_mt(MD_MTLO, 32'h5678);
    run_md(MD_DIVU, 32'd9, 32'd0, st, nb);
    n_cmp++;
    if (nb != DL || hi_o !== 32'h1234 || lo_o !== 32'h5678) begin
      n_err++;
      $display("FAIL div0 busy=%0d hi=%h lo=%h want %0d/1234/5678",
               nb, hi_o, lo_o, DL);
    end
    md_op = MD_MFHI;
    #1;
    n_cmp++;
    if (rd_data !== 32'h1234) begin
      n_err++;
      $display("FAIL div0_mfhi rd=%h want 1234", rd_data);
    end
    md_op = MD_NONE;
    mhi = 32'h1234; mlo = 32'h5678;
  endtask

  task automatic test_flush;
    int nb;
    logic [31:0] a;
    logic [31:0] b;
    @(negedge clk);
    md_op = MD_MULT; req = 1'b1;
    rs_val = $urandom; rt_val = $urandom;
    #1;
    n_cmp++;
    if (start !== 1'b0) begin
      n_err++;
      $display("FAIL flush_start start=%b want 0", start);
    end
    @(negedge clk);
    md_op = MD_MTHI; rs_val = 32'hDEAD0000;
    @(negedge clk);
    md_op = MD_NONE; req = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || hi_o !== mhi || lo_o !== mlo) begin
      n_err++;
      $display("FAIL flush_state busy=%b hi=%h lo=%h want 0/%h/%h",
               busy, hi_o, lo_o, mhi, mlo);
    end
    a = $urandom;
    b = $urandom_range(1, 1000);
    @(negedge clk);
    md_op = MD_DIV; rs_val = a; rt_val = b;
    @(negedge clk);
    md_op = MD_NONE;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      req = (nb >= 2 && nb <= 4);
      md_op = (nb == 5) ? MD_MULT : (nb == 6) ? MD_MTHI : MD_NONE;
      #1;
      if (nb == 5) begin
        n_cmp++;
        if (start !== 1'b0) begin
          n_err++;
          $display("FAIL busy_start start=%b want 0", start);
        end
      end
      @(negedge clk);
    end
    req = 1'b0; md_op = MD_NONE;
    model_op(MD_DIV, a, b);
    n_cmp++;
    if (nb != DL || hi_o !== mhi || lo_o !== mlo) begin
      n_err++;
      $display("FAIL req_mid_div busy=%0d hi=%h lo=%h want %0d/%h/%h",
               nb, hi_o, lo_o, DL, mhi, mlo);
    end
  endtask

  task automatic test_reset_mid;
    logic st; int nb;
    logic [31:0] a;
    logic [31:0] b;
    do_mt(MD_MTHI, 32'hAAAA5555);
    do_mt(MD_MTLO, 32'h5555AAAA);
    @(negedge clk);
    md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd3;
    @(negedge clk);
    md_op = MD_NONE;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid busy=%b hi=%h lo=%h want 0/0/0",
               busy, hi_o, lo_o);
    end
    @(negedge clk);
    reset = 1'b1;
    mhi = 0; mlo = 0;
    a = $urandom; b = $urandom;
    run_md(MD_MULT, a, b, st, nb);
    model_op(MD_MULT, a, b);
    n_cmp++;
    if (nb != ML || hi_o !== mhi || lo_o !== mlo) begin
      n_err++;
      $display("FAIL post_reset_mult busy=%0d hi=%h lo=%h want %0d/%h/%h",
               nb, hi_o, lo_o, ML, mhi, mlo);
    end
  endtask

  task automatic test_random;
    logic st; int nb; int lat;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 8));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'd0};
      if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
      if (op == MD_MFHI || op == MD_MFLO) begin
        @(negedge clk);
        md_op = op;
        #1;
        n_cmp++;
        if (rd_data !== ((op == MD_MFHI) ? mhi : mlo)) begin
          n_err++;
          $display("FAIL rnd_mf op=%0d rd=%h want %h", op, rd_data,
                   (op == MD_MFHI) ? mhi : mlo);
        end
        md_op = MD_NONE;
      end else if (op == MD_MTHI || op == MD_MTLO) begin
        do_mt(op, a);
        model_op(op, a, b);
      end else begin
        lat = (op == MD_MULT || op == MD_MULTU) ? ML : DL;
        run_md(op, a, b, st, nb);
        model_op(op, a, b);
        n_cmp++;
        if (st !== 1'b1 || nb != lat) begin
          n_err++;
          $display("FAIL rnd_lat op=%0d start=%b busy=%0d want 1/%0d",
                   op, st, nb, lat);
        end
      end
      n_cmp++;
      if (hi_o !== mhi || lo_o !== mlo) begin
        n_err++;
        $display("FAIL rnd_hilo op=%0d a=%h b=%h hi=%h lo=%h want %h/%h",
                 op, a, b, hi_o, lo_o, mhi, mlo);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    mhi = 0; mlo = 0;
    reset = 1'b0; req = 1'b0;
    md_op = MD_NONE; rs_val = 0; rt_val = 0;
    repeat (2) @(negedge clk);
    test_reset;
    test_mult_latency;
    test_multu;
    test_div;
    test_div_zero;
    test_flush;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
